mul_issue_ctrl: RTL and testbench
=================================

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 3, meaning clock cycles operands are held stable before the multiplier output is sampled; legal range 1..15.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 SHALL have port START  input  1  request to issue a multiply with the current DATA1/DATA2.
REQ-005 SHALL have port DATA1  input  8  operand A, sign-magnitude (bit 7 sign).
REQ-006 SHALL have port DATA2  input  8  operand B, sign-magnitude.
REQ-007 SHALL have port MUL_IN  input  8  combinational product returned by the downstream multiplier.
REQ-008 SHALL have port ACK  input  1  consumer accepts RESULT.
REQ-009 SHALL have port OP_A  output  8  registered operand A driven to the multiplier.
REQ-010 SHALL have port OP_B  output  8  registered operand B driven to the multiplier.
REQ-011 SHALL have port RESULT  output  8  registered product.
REQ-012 SHALL have port VALID  output  1  RESULT holds a completed, unacknowledged product.
REQ-013 SHALL have port BUSY  output  1  high while in SETTLE; used as a CPU stall.
REQ-014 SHALL have port ZERO  output  1  registered flag, RESULT magnitude bits [6:0] equal 0.
REQ-015 SHALL have port OP_COUNT  output  8  count of completed multiplies.

Function
REQ-016 SHALL implement states IDLE, SETTLE, DONE; VALID=1 only in DONE, BUSY=1 only in SETTLE.
REQ-017 SHALL, in IDLE with START=1 at an edge, load OP_A<=DATA1, OP_B<=DATA2, load a 4-bit counter with SETTLE_CYCLES, enter SETTLE.
REQ-018 SHALL, in SETTLE, decrement the counter each edge; at the edge where counter==1, load RESULT<=MUL_IN, update ZERO, increment OP_COUNT, enter DONE.
REQ-019 SHALL give latency: START sampled at edge k -> VALID=1 and RESULT updated after edge k+SETTLE_CYCLES.
REQ-020 SHALL hold OP_A/OP_B unchanged from issue until the next accepted START; START and DATA1/DATA2 changes in SETTLE are ignored.
REQ-021 SHALL, in DONE, hold RESULT, ZERO, VALID stable until ACK=1 at an edge.
REQ-022 SHALL, in DONE with ACK=1 and START=0, return to IDLE; with ACK=1 and START=1, load new operands and enter SETTLE in the same edge (back-to-back issue, no IDLE cycle).
REQ-023 SHALL ignore START in DONE while ACK=0 (no overwrite of unacknowledged result).
REQ-024 SHALL ignore ACK in IDLE and SETTLE.
REQ-025 SHALL treat negative zero (MUL_IN=8'h80) as zero for ZERO=1 and pass RESULT through unmodified.
REQ-026 SHALL wrap OP_COUNT from 8'hFF to 8'h00 without side effects.
REQ-027 SHALL, with SETTLE_CYCLES=1, sample MUL_IN on the edge following issue.

Reset
REQ-028 SHALL, while RESET=0, force state IDLE and OP_A, OP_B, RESULT, OP_COUNT=8'h00, VALID, BUSY, ZERO=0, counter=0, independent of CLK.
REQ-029 SHALL abort an in-flight SETTLE on reset with no VALID pulse and no OP_COUNT increment.
REQ-030 SHALL resume normal operation on the first rising edge after RESET returns to 1, sampling START on that edge.

Verification
REQ-031 SHALL cover: reset, DATA1=8'h03, DATA2=8'h05, START one cycle, model MUL_IN=8'h0F -> BUSY 3 cycles, then VALID=1, RESULT=8'h0F, ZERO=0, OP_COUNT=1.
REQ-032 SHALL cover: DATA1=8'h83, DATA2=8'h05, MUL_IN=8'h8F, ACK held 0 for 5 cycles with START=1 and DATA1 changed -> RESULT stays 8'h8F, OP_A stays 8'h83, VALID stays 1.
REQ-033 SHALL cover: in DONE, ACK=1 and START=1 with DATA1=8'h02, DATA2=8'h04 -> next cycle BUSY=1, VALID=0, OP_A=8'h02, OP_B=8'h04; RESULT=8'h08 after 3 more edges.
REQ-034 SHALL cover: RESET=0 asynchronously mid-SETTLE -> all outputs 0 immediately, no VALID after release, OP_COUNT unchanged at 0.
REQ-035 SHALL cover: MUL_IN=8'h80 (8'h80 x 8'h05) -> ZERO=1, RESULT=8'h80.
REQ-036 SHALL cover: 256 back-to-back operations -> OP_COUNT wraps to 8'h00; rerun with SETTLE_CYCLES=1 gives VALID one edge after issue.

Source files
------------

// File: rtl/mul_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl_if
//   Bundles the issue/result signals of mul_issue_ctrl.
//
//   Handshake: START is a request that is taken only at a rising edge where
//   the controller is free, meaning IDLE, or DONE with ACK=1 on that same
//   edge. VALID=1 means RESULT/ZERO hold a finished, unacknowledged product.
//   They stay stable until ACK=1 is seen at a rising edge while VALID=1.
//   ACK has no effect while VALID=0.
//
//   Signals
//     START, DATA1, DATA2 : issue request and sign-magnitude operands
//     MUL_IN              : combinational product from the external multiplier
//     ACK                 : consumer accepts RESULT
//     OP_A, OP_B          : registered operands driven to the multiplier
//     RESULT, ZERO        : registered product and its magnitude-is-zero flag
//     VALID, BUSY         : result pending / operands settling (stall)
//     OP_COUNT            : number of completed multiplies (wraps)
//
//   Modports
//     master : requester/testbench side
//     slave  : controller side
// ---------------------------------------------------------------------------
interface mul_issue_ctrl_if;
    logic       START;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] MUL_IN;
    logic       ACK;
    logic [7:0] OP_A;
    logic [7:0] OP_B;
    logic [7:0] RESULT;
    logic       VALID;
    logic       BUSY;
    logic       ZERO;
    logic [7:0] OP_COUNT;

    modport master (
        output START, DATA1, DATA2, MUL_IN, ACK,
        input  OP_A, OP_B, RESULT, VALID, BUSY, ZERO, OP_COUNT
    );

    modport slave (
        input  START, DATA1, DATA2, MUL_IN, ACK,
        output OP_A, OP_B, RESULT, VALID, BUSY, ZERO, OP_COUNT
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl
//   Issues one multiply to an external combinational multiplier. It holds
//   the operands stable for SETTLE_CYCLES clocks, samples the product, and
//   then keeps it until the consumer acknowledges it.
//
//   Parameters
//     SETTLE_CYCLES : cycles between issue and sampling MUL_IN (1..15)
//
//   Ports
//     CLK       : clock, rising edge
//     RESET     : asynchronous reset, active low
//     bus       : mul_issue_ctrl_if.slave (see interface for the handshake)
//     state_dbg : current FSM state (0 IDLE, 1 SETTLE, 2 DONE)
// ---------------------------------------------------------------------------
module mul_issue_ctrl #(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic            CLK,
    input  logic            RESET,
    mul_issue_ctrl_if.slave bus,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       issue;
    logic       capture;

    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] result;
    logic [7:0] op_count;
    logic       zero;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // issue   : load operands and restart the settle countdown
    // capture : the edge where the multiplier output has settled
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    issue      = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd1) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Back-to-back issue: an acknowledged result frees the slot
                // in the same edge, so a waiting START is taken right away.
                if (bus.ACK) begin
                    if (bus.START) begin
                        issue      = 1'b1;
                        state_next = SETTLE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            op_a     <= 8'h00;
            op_b     <= 8'h00;
            result   <= 8'h00;
            op_count <= 8'h00;
            zero     <= 1'b0;
            cnt      <= 4'd0;
        end else begin
            if (issue) begin
                op_a <= bus.DATA1;
                op_b <= bus.DATA2;
                cnt  <= SETTLE_INIT;
            end else if (state == SETTLE) begin
                cnt <= cnt - 4'd1;
            end

            if (capture) begin
                result   <= bus.MUL_IN;
                // Sign bit is ignored so negative zero (8'h80) counts as zero.
                zero     <= (bus.MUL_IN[6:0] == 7'd0);
                op_count <= op_count + 8'd1;
            end
        end
    end

    assign bus.OP_A     = op_a;
    assign bus.OP_B     = op_b;
    assign bus.RESULT   = result;
    assign bus.ZERO     = zero;
    assign bus.OP_COUNT = op_count;
    assign bus.VALID    = (state == DONE);
    assign bus.BUSY     = (state == SETTLE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_issue_ctrl
//   Drives two controllers from the same request stream: one with
//   SETTLE_CYCLES=3 and one with SETTLE_CYCLES=1. Each controller has its own
//   multiplier stand-in. A transaction-level reference model predicts every
//   output after each clock edge and after each asynchronous reset.
//   The stand-in drives the true product only during the cycle in which a
//   correct controller samples it. In every other cycle it drives noise, so
//   sampling MUL_IN at the wrong time shows up in RESULT.
// ---------------------------------------------------------------------------
module tb_mul_issue_ctrl;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    // ---------------- shared request stimulus ----------------
    logic       t_start;
    logic       t_ack;
    logic [7:0] t_d1;
    logic [7:0] t_d2;
    logic [7:0] mul_in [2];

    mul_issue_ctrl_if bus3 ();
    mul_issue_ctrl_if bus1 ();
    logic [1:0] dbg3;
    logic [1:0] dbg1;

    assign bus3.START  = t_start;
    assign bus3.ACK    = t_ack;
    assign bus3.DATA1  = t_d1;
    assign bus3.DATA2  = t_d2;
    assign bus3.MUL_IN = mul_in[0];
    assign bus1.START  = t_start;
    assign bus1.ACK    = t_ack;
    assign bus1.DATA1  = t_d1;
    assign bus1.DATA2  = t_d2;
    assign bus1.MUL_IN = mul_in[1];

    mul_issue_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .CLK(CLK), .RESET(RESET), .bus(bus3.slave), .state_dbg(dbg3)
    );
    mul_issue_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(bus1.slave), .state_dbg(dbg1)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_left: edges still to go before the product is taken (0 = not settling)
    int         s_cyc [2] = '{3, 1};
    int         m_left [2];
    logic       m_valid [2];
    logic [7:0] m_opa [2];
    logic [7:0] m_opb [2];
    logic [7:0] m_result [2];
    logic       m_zero [2];
    logic [7:0] m_count [2];

    // Sign-magnitude product, magnitude truncated to 7 bits.
    function automatic logic [7:0] smmul(input logic [7:0] a, input logic [7:0] b);
        int mag;
        mag = (int'(a[6:0]) * int'(b[6:0])) % 128;
        return {a[7] ^ b[7], 7'(mag)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_left[i]   = 0;
            m_valid[i]  = 1'b0;
            m_opa[i]    = 8'h00;
            m_opb[i]    = 8'h00;
            m_result[i] = 8'h00;
            m_zero[i]   = 1'b0;
            m_count[i]  = 8'h00;
        end
    endtask

    task automatic model_issue(input int i);
        m_opa[i]  = t_d1;
        m_opb[i]  = t_d2;
        m_left[i] = s_cyc[i];
    endtask

    task automatic model_edge(input int i);
        if (m_valid[i]) begin
            if (t_ack) begin
                m_valid[i] = 1'b0;
                if (t_start) model_issue(i);
            end
        end else if (m_left[i] > 0) begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
                m_valid[i]  = 1'b1;
                m_result[i] = smmul(m_opa[i], m_opb[i]);
                m_zero[i]   = (m_result[i][6:0] == 7'd0);
                m_count[i]  = m_count[i] + 8'd1;
            end
        end else if (t_start) begin
            model_issue(i);
        end
    endtask

    // Multiplier stand-in: true product only in the cycle it must be sampled.
    task automatic drive_mul();
        for (int i = 0; i < 2; i++) begin
            if (m_left[i] == 1) mul_in[i] = smmul(m_opa[i], m_opb[i]);
            else                mul_in[i] = 8'($urandom);
        end
    endtask

    task automatic check_dut(input int i, input logic [7:0] opa, input logic [7:0] opb,
                             input logic [7:0] res, input logic valid, input logic busy,
                             input logic zero, input logic [7:0] cnt);
        string p;
        p = $sformatf("s%0d.", s_cyc[i]);
        check({p, "op_a"},     32'(opa),   32'(m_opa[i]));
        check({p, "op_b"},     32'(opb),   32'(m_opb[i]));
        check({p, "result"},   32'(res),   32'(m_result[i]));
        check({p, "valid"},    32'(valid), 32'(m_valid[i]));
        check({p, "busy"},     32'(busy),  32'(m_left[i] > 0));
        check({p, "zero"},     32'(zero),  32'(m_zero[i]));
        check({p, "op_count"}, 32'(cnt),   32'(m_count[i]));
    endtask

    task automatic check_all();
        check_dut(0, bus3.OP_A, bus3.OP_B, bus3.RESULT, bus3.VALID, bus3.BUSY,
                  bus3.ZERO, bus3.OP_COUNT);
        check_dut(1, bus1.OP_A, bus1.OP_B, bus1.RESULT, bus1.VALID, bus1.BUSY,
                  bus1.ZERO, bus1.OP_COUNT);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
        drive_mul();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Pulse reset between edges (called 1 ns after an edge).
    task automatic async_reset();
        #2 RESET = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 RESET = 1'b1;
        drive_mul();
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        t_d1    = a;
        t_d2    = b;
        t_start = 1'b1;
        step();
        t_start = 1'b0;
    endtask

    task automatic ack_once();
        t_ack = 1'b1;
        step();
        t_ack = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        t_start = 1'b0;
        t_ack   = 1'b0;
        t_d1    = 8'h00;
        t_d2    = 8'h00;
        RESET   = 1'b1;
        model_reset();
        drive_mul();
        #1 RESET = 1'b0;
        #1;
        check_all();
        repeat (2) @(posedge CLK);
        @(negedge CLK) RESET = 1'b1;

        // Reset in the middle of SETTLE: no result, no count.
        issue(8'h03, 8'h05);
        step();
        async_reset();
        check("rst_mid.valid", 32'(bus3.VALID), 32'h0);
        check("rst_mid.op_a", 32'(bus3.OP_A), 32'h00);
        steps(5);
        check("rst_mid.op_count", 32'(bus3.OP_COUNT), 32'h00);

        // 3 x 5: BUSY for three cycles, then result 8'h0F.
        issue(8'h03, 8'h05);
        check("basic.busy", 32'(bus3.BUSY), 32'h1);
        steps(3);
        check("basic.valid", 32'(bus3.VALID), 32'h1);
        check("basic.result", 32'(bus3.RESULT), 32'h0F);
        check("basic.zero", 32'(bus3.ZERO), 32'h0);
        check("basic.op_count", 32'(bus3.OP_COUNT), 32'h01);
        ack_once();

        // Unacknowledged result is kept while START and DATA1 keep moving.
        issue(8'h83, 8'h05);
        steps(3);
        t_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            t_d1 = 8'($urandom);
            step();
        end
        check("hold.result", 32'(bus3.RESULT), 32'h8F);
        check("hold.op_a", 32'(bus3.OP_A), 32'h83);
        check("hold.valid", 32'(bus3.VALID), 32'h1);
        t_start = 1'b0;
        ack_once();

        // ACK together with START reissues in the same edge.
        issue(8'h03, 8'h05);
        steps(3);
        t_ack   = 1'b1;
        t_start = 1'b1;
        t_d1    = 8'h02;
        t_d2    = 8'h04;
        step();
        t_ack   = 1'b0;
        t_start = 1'b0;
        check("b2b.busy", 32'(bus3.BUSY), 32'h1);
        check("b2b.valid", 32'(bus3.VALID), 32'h0);
        check("b2b.op_a", 32'(bus3.OP_A), 32'h02);
        check("b2b.op_b", 32'(bus3.OP_B), 32'h04);
        steps(3);
        check("b2b.result", 32'(bus3.RESULT), 32'h08);
        ack_once();

        // Negative zero counts as zero, and RESULT keeps the sign bit.
        issue(8'h80, 8'h05);
        steps(3);
        check("negzero.zero", 32'(bus3.ZERO), 32'h1);
        check("negzero.result", 32'(bus3.RESULT), 32'h80);
        ack_once();

        // SETTLE_CYCLES=1: VALID one edge after issue.
        async_reset();
        issue(8'h07, 8'h09);
        step();
        check("s1.valid", 32'(bus1.VALID), 32'h1);
        check("s1.result", 32'(bus1.RESULT), 32'h3F);
        check("s1.s3_busy", 32'(bus3.BUSY), 32'h1);

        // 256 back-to-back operations wrap OP_COUNT (the 4-cycle period for SETTLE_CYCLES=3).
        async_reset();
        t_start = 1'b1;
        t_ack   = 1'b1;
        for (int k = 0; k < 1023; k++) begin
            t_d1 = 8'($urandom);
            t_d2 = 8'($urandom);
            step();
        end
        check("wrap.count_ff", 32'(bus3.OP_COUNT), 32'hFF);
        step();
        check("wrap.count_00", 32'(bus3.OP_COUNT), 32'h00);
        check("wrap.valid", 32'(bus3.VALID), 32'h1);
        check("wrap.s1_count", 32'(bus1.OP_COUNT), 32'h00);

        // Random traffic with occasional asynchronous resets.
        for (int k = 0; k < 1500; k++) begin
            t_start = ($urandom_range(0, 3) != 0);
            t_ack   = ($urandom_range(0, 1) == 1);
            t_d1    = 8'($urandom);
            t_d2    = 8'($urandom);
            if ($urandom_range(0, 99) == 0) async_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
